// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit active-low seven-segment scanner with double-buffered digit bank,
// programmable on-time and blanking gap, frame-boundary commit of the shadow bank.
module seg_scan_ctrl #(
    parameter int ON_CYC  = 50000,
    parameter int GAP_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       wr_blank,
    input  logic       commit,
    output logic       commit_pend,
    output logic [3:0] cs_n,
    output logic [7:0] dx,
    output logic       frame_done
);
    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_GAP = 2'd1;
    localparam logic [1:0] S_ON  = 2'd2;
    localparam logic [15:0] ON_LAST  = 16'(ON_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [5:0] BLANK = 6'b10_0000;

    logic [1:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [3:0]  cs_n_q, cs_n_d;
    logic [7:0]  dx_q, dx_d;
    logic        fd_q, fd_d;
    logic [5:0]  shadow_q [4];
    logic [5:0]  active_q [4];
    logic        off_w, on_end, boundary, copy;
    logic [5:0]  cur;

    function automatic logic [7:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
    endfunction

    // Any encoding other than GAP/ON behaves as OFF, so a corrupted state recovers.
    assign off_w    = state_q != S_GAP && state_q != S_ON;
    assign on_end   = state_q == S_ON && cnt_q == ON_LAST;
    assign boundary = en && (off_w || (on_end && idx_q == 2'd3));
    assign copy     = boundary && (pend_q || commit);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 16'd1;
        if (!en) begin
            state_d = S_OFF;
            idx_d   = 2'd0;
            cnt_d   = 16'd0;
        end else if (off_w) begin
            state_d = S_GAP;
            idx_d   = 2'd0;
            cnt_d   = 16'd0;
        end else if (state_q == S_GAP && cnt_q == GAP_LAST) begin
            state_d = S_ON;
            cnt_d   = 16'd0;
        end else if (on_end) begin
            state_d = S_GAP;
            idx_d   = idx_q + 2'd1;
            cnt_d   = 16'd0;
        end
    end

    // Active bank only changes on GAP entry, so it is stable whenever ON is entered.
    assign cur    = active_q[idx_d];
    assign pend_d = boundary ? 1'b0 : (pend_q | commit);
    assign fd_d   = en && on_end && idx_q == 2'd3;
    assign cs_n_d = state_d == S_ON ? ~(4'b0001 << idx_d) : 4'hF;
    assign dx_d   = (state_d == S_ON && !cur[5]) ? (seg(cur[3:0]) & ~{cur[4], 7'b0}) : 8'hFF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            idx_q    <= 2'd0;
            cnt_q    <= 16'd0;
            pend_q   <= 1'b0;
            cs_n_q   <= 4'hF;
            dx_q     <= 8'hFF;
            fd_q     <= 1'b0;
            shadow_q <= '{default: BLANK};
            active_q <= '{default: BLANK};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cs_n_q  <= cs_n_d;
            dx_q    <= dx_d;
            fd_q    <= fd_d;
            if (copy) active_q <= shadow_q;
            if (wr_en) shadow_q[wr_addr] <= {wr_blank, wr_dp, wr_data};
        end
    end

    assign commit_pend = pend_q;
    assign cs_n        = cs_n_q;
    assign dx          = dx_q;
    assign frame_done  = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: vector table, directed corner sequences and random traffic against
// a time-position model of the scan (frame offset arithmetic, not a state machine).
module tb_seg_scan_ctrl;
    localparam int ON = 4;
    localparam int GAP = 2;
    localparam int SLOT = ON + GAP;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, en = 1'b0, wr_en = 1'b0, wr_dp = 1'b0, wr_blank = 1'b0, commit = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       commit_pend, frame_done;
    logic [3:0] cs_n;
    logic [7:0] dx;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.ON_CYC(ON), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank), .commit(commit),
        .commit_pend(commit_pend), .cs_n(cs_n), .dx(dx), .frame_done(frame_done)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [5:0] m_sh [4];
    logic [5:0] m_ac [4];
    logic       m_pend, m_run, m_fd;
    int         m_t;

    typedef struct {
        logic r, e, w;
        logic [1:0] a;
        logic [3:0] d;
        logic p, b, c;
        logic [3:0] cs;
        logic [7:0] dx;
        logic fd, pend;
    } vec_t;
    vec_t tv [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] m_out();
        logic [3:0] c;
        logic [7:0] x;
        logic [5:0] e;
        c = 4'hF;
        x = 8'hFF;
        if (m_run && (m_t % SLOT) >= GAP) begin
            e = m_ac[m_t / SLOT];
            c = ~(4'b0001 << (m_t / SLOT));
            x = e[5] ? 8'hFF : (seg_tab[e[3:0]] & ~{e[4], 7'b0});
        end
        return {c, x, m_fd, m_pend};
    endfunction

    task automatic model_step(input logic r, e, w, input logic [1:0] a, input logic [3:0] d,
                              input logic p, b, c);
        logic bnd;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[i] = 6'h20;
                m_ac[i] = 6'h20;
            end
            m_pend = 1'b0;
            m_run = 1'b0;
            m_fd = 1'b0;
            m_t = 0;
        end else begin
            bnd = 1'b0;
            m_fd = 1'b0;
            if (!e) begin
                m_run = 1'b0;
                m_t = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t = 0;
                bnd = 1'b1;
            end else begin
                m_t = (m_t + 1) % FRAME;
                if (m_t == 0) begin
                    bnd = 1'b1;
                    m_fd = 1'b1;
                end
            end
            if (bnd && (m_pend || c)) for (int i = 0; i < 4; i++) m_ac[i] = m_sh[i];
            m_pend = bnd ? 1'b0 : (m_pend | c);
            if (w) m_sh[a] = {b, p, d};
        end
    endtask

    task automatic cyc(input logic r, e, w, input logic [1:0] a, input logic [3:0] d,
                       input logic p, b, c);
        rst_n = r; en = e; wr_en = w; wr_addr = a; wr_data = d; wr_dp = p; wr_blank = b; commit = c;
        @(posedge clk);
        model_step(r, e, w, a, d, p, b, c);
        #1;
        check("model", {18'd0, cs_n, dx, frame_done, commit_pend}, {18'd0, m_out()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 2'd0, 4'd0, 0, 0, 0);
    endtask

    task automatic wait_cs(input logic [3:0] tgt, input string name);
        int k;
        k = 0;
        while (cs_n !== tgt && k < 4 * FRAME) begin
            idle(1);
            k++;
        end
        check(name, {28'd0, cs_n}, {28'd0, tgt});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic [3:0]  prev;
        int          bad;
        tv[0]  = '{0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[1]  = '{0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[2]  = '{1, 0, 1, 2'd0, 4'd1, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[3]  = '{1, 0, 1, 2'd1, 4'd2, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[4]  = '{1, 0, 1, 2'd2, 4'd3, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[5]  = '{1, 0, 1, 2'd3, 4'd4, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[6]  = '{1, 0, 0, 2'd0, 4'd0, 0, 0, 1, 4'hF, 8'hFF, 0, 1};
        tv[7]  = '{1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[8]  = '{1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        for (int i = 9; i < 13; i++) tv[i] = '{1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 4'hE, 8'hF9, 0, 0};
        tv[13] = '{1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[14] = '{1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 4'hF, 8'hFF, 0, 0};
        tv[15] = '{1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 4'hD, 8'hA4, 0, 0};

        for (int i = 0; i < 16; i++) begin
            cyc(tv[i].r, tv[i].e, tv[i].w, tv[i].a, tv[i].d, tv[i].p, tv[i].b, tv[i].c);
            check($sformatf("vec%0d", i), {18'd0, cs_n, dx, frame_done, commit_pend},
                  {18'd0, tv[i].cs, tv[i].dx, tv[i].fd, tv[i].pend});
        end

        // Mid-frame updates: E+9 .. E+24
        idle(1);
        cyc(1, 1, 1, 2'd2, 4'd8, 1, 0, 0);
        cyc(1, 1, 1, 2'd3, 4'd0, 0, 1, 0);
        cyc(1, 1, 1, 2'd0, 4'hF, 0, 0, 0);
        cyc(1, 1, 0, 2'd0, 4'd0, 0, 0, 1);
        check("pend_after_commit", {31'd0, commit_pend}, 32'd1);
        idle(1);
        check("slot2_old", {20'd0, cs_n, dx}, {20'd0, 4'hB, 8'hB0});
        idle(9);
        check("pre_boundary", {30'd0, frame_done, commit_pend}, {30'd0, 2'b01});
        idle(1);
        check("frame_done_E24", {30'd0, frame_done, commit_pend}, {30'd0, 2'b10});
        wait_cs(4'hE, "wait_slot0");
        check("slot0_F", {24'd0, dx}, {24'd0, 8'h8E});
        wait_cs(4'hB, "wait_slot2");
        check("slot2_dp8", {24'd0, dx}, 32'd0);
        wait_cs(4'h7, "wait_slot3");
        check("slot3_blank", {24'd0, dx}, {24'd0, 8'hFF});

        // Write + commit on the boundary edge itself
        idle(ON - 1);
        cyc(1, 1, 1, 2'd1, 4'hA, 0, 0, 1);
        check("coinc_edge", {30'd0, frame_done, commit_pend}, {30'd0, 2'b10});
        wait_cs(4'hD, "wait_coinc_d1");
        check("coinc_old", {24'd0, dx}, {24'd0, 8'hA4});
        cyc(1, 1, 0, 2'd0, 4'd0, 0, 0, 1);
        check("coinc_pend", {31'd0, commit_pend}, 32'd1);
        wait_cs(4'hE, "wait_next_frame");
        check("coinc_pend_clr", {31'd0, commit_pend}, 32'd0);
        wait_cs(4'hD, "wait_d1_new");
        check("coinc_new", {24'd0, dx}, {24'd0, 8'h88});

        // Disable during ON(idx=2), commit while dark
        wait_cs(4'hB, "wait_dis");
        cyc(1, 0, 0, 2'd0, 4'd0, 0, 0, 0);
        check("dis_dark", {20'd0, cs_n, dx}, {20'd0, 4'hF, 8'hFF});
        cyc(1, 0, 1, 2'd0, 4'd5, 0, 0, 0);
        cyc(1, 0, 0, 2'd0, 4'd0, 0, 0, 1);
        cyc(1, 0, 0, 2'd0, 4'd0, 0, 0, 0);
        check("dis_pend_held", {31'd0, commit_pend}, 32'd1);
        idle(1);
        check("reen_pend", {27'd0, cs_n, commit_pend}, {27'd0, 4'hF, 1'b0});
        idle(GAP - 1);
        check("reen_gap", {28'd0, cs_n}, {28'd0, 4'hF});
        idle(1);
        check("reen_slot0", {20'd0, cs_n, dx}, {20'd0, 4'hE, 8'h92});

        // Reset mid-ON with en held high
        wait_cs(4'hD, "wait_rst");
        cyc(0, 1, 0, 2'd0, 4'd0, 0, 0, 1);
        check("rst_out", {19'd0, cs_n, dx, commit_pend}, {19'd0, 4'hF, 8'hFF, 1'b0});
        cyc(0, 1, 0, 2'd0, 4'd0, 0, 0, 0);
        seq = 16'd0;
        prev = 4'hF;
        bad = 0;
        for (int i = 0; i < FRAME + 1; i++) begin
            idle(1);
            if (dx !== 8'hFF) bad++;
            if (cs_n !== 4'hF && cs_n !== prev) seq = {seq[11:0], cs_n};
            prev = cs_n;
        end
        check("rst_blank_dx", bad, 0);
        check("rst_seq", {16'd0, seq}, {16'd0, 16'hEDB7});

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 599) != 0, $urandom_range(0, 79) != 0, $urandom_range(0, 3) == 0,
                2'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                $urandom_range(0, 29) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
